// File: rtl/button_event_pkg.sv
// Shared definitions for the button event block: FSM state encoding and the
// control codes of the generic register, kept identical to the debouncer's.
package button_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2,
        ST_REPEAT  = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_NONE = 2'd0;
    localparam logic [1:0] CTRL_LOAD = 2'd2;
    localparam logic [1:0] CTRL_INCR = 2'd3;

    // held is asserted in both post-long-press states
    function automatic logic is_held(input state_t s);
        return (s == ST_LONG) || (s == ST_REPEAT);
    endfunction

endpackage

// File: rtl/button_event_register.sv
// Generic parameterised register: holds, loads or increments under a 2-bit
// control code shared with the rest of the controller.
import button_event_pkg::*;

module register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ctrl,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] q_r;

    // storage element; unknown control codes hold the current value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (ctrl)
                CTRL_LOAD: q_r <= d;
                CTRL_INCR: q_r <= q_r + ONE;
                default:   q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into registered press, release, long-press
// and auto-repeat pulses plus a held level.
import button_event_pkg::*;

module button_event #(
    parameter int CNT_WIDTH     = 26,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    // one extra bit so cnt+1 can never alias a threshold through wrap-around
    localparam logic [CNT_WIDTH:0] LONG_THR   = (CNT_WIDTH+1)'(LONG_CYCLES);
    localparam logic [CNT_WIDTH:0] REPEAT_THR = (CNT_WIDTH+1)'(REPEAT_CYCLES);
    localparam logic [CNT_WIDTH:0] CNT_ONE    = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 lvl_r;
    logic                 armed_r;
    logic                 rise_s;
    logic [1:0]           cnt_ctrl_s;
    logic [CNT_WIDTH-1:0] cnt_s;
    logic [CNT_WIDTH:0]   cnt_inc_s;
    logic                 press_s;
    logic                 release_s;
    logic                 long_s;
    logic                 repeat_s;
    logic                 press_r;
    logic                 release_r;
    logic                 long_r;
    logic                 repeat_r;
    logic                 held_r;

    register #(
        .DATA_WIDTH(CNT_WIDTH)
    ) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .ctrl (cnt_ctrl_s),
        .d    ({CNT_WIDTH{1'b0}}),
        .q    (cnt_s)
    );

    // armed_r blocks a spurious press when the button is already down as reset lifts
    assign rise_s    = armed_r & btn_level & ~lvl_r;
    assign cnt_inc_s = {1'b0, cnt_s} + CNT_ONE;

    // next-state, counter control and pulse decisions
    always_comb begin
        state_nxt_s = state_r;
        cnt_ctrl_s  = CTRL_NONE;
        press_s     = 1'b0;
        release_s   = 1'b0;
        long_s      = 1'b0;
        repeat_s    = 1'b0;
        if (!en) begin
            state_nxt_s = ST_IDLE;
            cnt_ctrl_s  = CTRL_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        press_s     = 1'b1;
                        cnt_ctrl_s  = CTRL_LOAD;
                        state_nxt_s = ST_PRESSED;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_level) begin
                        release_s   = 1'b1;
                        cnt_ctrl_s  = CTRL_LOAD;
                        state_nxt_s = ST_IDLE;
                    end else if (cnt_inc_s == LONG_THR) begin
                        long_s      = 1'b1;
                        cnt_ctrl_s  = CTRL_LOAD;
                        state_nxt_s = ST_LONG;
                    end else begin
                        cnt_ctrl_s  = CTRL_INCR;
                    end
                end
                ST_LONG, ST_REPEAT: begin
                    if (!btn_level) begin
                        release_s   = 1'b1;
                        cnt_ctrl_s  = CTRL_LOAD;
                        state_nxt_s = ST_IDLE;
                    end else if (cnt_inc_s == REPEAT_THR) begin
                        repeat_s    = 1'b1;
                        cnt_ctrl_s  = CTRL_LOAD;
                        state_nxt_s = ST_REPEAT;
                    end else begin
                        cnt_ctrl_s  = CTRL_INCR;
                    end
                end
                default: begin
                    cnt_ctrl_s  = CTRL_LOAD;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // state register plus level sampling, which runs regardless of en or state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            lvl_r   <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            lvl_r   <= btn_level;
            armed_r <= 1'b1;
        end
    end

    // output registers, aligned with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            press_r   <= press_s;
            release_r <= release_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
            held_r    <= is_held(state_nxt_s);
        end
    end

    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;
    assign held          = held_r;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: a time-since-press reference model queues
// the expected outputs of every edge; a monitor compares them after the edge.
module tb_button_event;

    localparam int CW   = 4;
    localparam int LONG = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b1;
    logic btn_level = 1'b1;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    button_event #(
        .CNT_WIDTH(CW),
        .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .held(held)
    );

    always #5 clk = ~clk;

    // expected vector: {press, release, long, repeat, held}
    logic [4:0] exp_q[$];
    int  checks = 0;
    int  passed = 0;
    bit  started = 1'b0;

    // reference model: "is a press active" and "edges since the press"
    bit m_active = 1'b0;
    int m_t = 0;
    bit m_prev = 1'b0;
    bit m_first = 1'b1;

    function automatic logic [4:0] model_edge(input logic b, input logic e, input logic r);
        logic [4:0] v;
        bit rise;
        v = 5'b00000;
        if (!r) begin
            m_active = 1'b0;
            m_first  = 1'b1;
            m_prev   = 1'b0;
            return v;
        end
        rise = !m_first && b && !m_prev;
        if (!e) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (rise) begin
                v[4] = 1'b1;
                m_active = 1'b1;
                m_t = 0;
            end
        end else if (!b) begin
            v[3] = 1'b1;
            m_active = 1'b0;
        end else begin
            m_t++;
            if (m_t == LONG) v[2] = 1'b1;
            else if (m_t > LONG && ((m_t - LONG) % REP) == 0) v[1] = 1'b1;
        end
        v[0] = m_active && (m_t >= LONG);
        m_prev  = b;
        m_first = 1'b0;
        return v;
    endfunction

    task automatic step(input logic b, input logic e, input logic r);
        @(negedge clk);
        btn_level = b;
        en = e;
        rst = r;
        exp_q.push_back(model_edge(b, e, r));
        started = 1'b1;
    endtask

    task automatic run(input logic b, input logic e, input int n);
        for (int i = 0; i < n; i++) step(b, e, 1'b1);
    endtask

    // monitor: compare each edge's outputs with the queued expectation
    initial begin
        logic [4:0] act;
        logic [4:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                act = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_empty at %0t: got %b, no expectation queued", $time, act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act === exp) passed++;
                    else $display("FAIL outputs at %0t: got {p,r,l,rp,h}=%b required %b", $time, act, exp);
                end
            end
        end
    end

    initial begin
        int hold_len, low_len;
        logic e;
        // reset held with the button already down: outputs must be zero, and
        // releasing reset must not produce a press
        run(1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        run(1'b1, 1'b1, 20);
        // short press
        run(1'b0, 1'b1, 5);
        run(1'b1, 1'b1, 3);
        run(1'b0, 1'b1, 5);
        // long press with two repeats, released on a repeat boundary
        run(1'b1, 1'b1, 20);
        run(1'b0, 1'b1, 5);
        // release coincides with the long threshold
        run(1'b1, 1'b1, 8);
        run(1'b0, 1'b1, 5);
        // enable abort while held, then a fresh press
        run(1'b1, 1'b1, 4);
        run(1'b1, 1'b0, 2);
        run(1'b1, 1'b1, 9);
        run(1'b0, 1'b1, 2);
        run(1'b1, 1'b1, 3);
        run(1'b0, 1'b1, 3);
        // back-to-back press
        run(1'b1, 1'b1, 2);
        run(1'b0, 1'b1, 1);
        run(1'b1, 1'b1, 2);
        run(1'b0, 1'b1, 3);
        // reset mid-hold
        run(1'b1, 1'b1, 12);
        step(1'b1, 1'b1, 1'b0);
        run(1'b1, 1'b1, 5);
        run(1'b0, 1'b1, 2);
        // randomized holds with occasional enable drops and resets
        for (int k = 0; k < 150; k++) begin
            hold_len = $urandom_range(1, 30);
            low_len  = $urandom_range(1, 4);
            for (int i = 0; i < hold_len + low_len; i++) begin
                e = ($urandom_range(0, 39) != 0);
                step((i < hold_len) ? 1'b1 : 1'b0, e, ($urandom_range(0, 299) != 0));
            end
        end
        run(1'b0, 1'b1, 3);
        @(negedge clk);
        started = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
